// File: rtl/snn_pkg.sv
//------------------------------------------------------------------------------
// snn_pkg : shared types and constants for the spike encoder front end
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

package snn_pkg;

  localparam int          CHANNELS  = 8;
  localparam int          INT_W     = 4;
  // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef logic [INT_W-1:0] intensity_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/spike_gen_lane.sv
//------------------------------------------------------------------------------
// spike_gen_lane : one spike line, accumulator overflow or LFSR comparator
// Rev 1.0 : initial release (build option SPIKE_ENCODER_LFSR_EN)
//------------------------------------------------------------------------------
`default_nettype none

module spike_gen_lane #(
  parameter int INT_W = snn_pkg::INT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [INT_W-1:0] intensity_i,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [INT_W-1:0] lfsr_slice_i,
  output logic             spike_o
);

  logic spike_q;

`ifdef SPIKE_ENCODER_LFSR_EN
  logic unused_clear;
  assign unused_clear = clear_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) spike_q <= 1'b0;
    else        spike_q <= enable_i && (intensity_i > lfsr_slice_i);
  end
`else
  logic [INT_W-1:0] acc_q, acc_d, sum;
  logic             carry;
  logic             unused_slice;
  assign unused_slice = ^lfsr_slice_i;

  always_comb begin
    {carry, sum} = {1'b0, acc_q} + {1'b0, intensity_i};
    acc_d        = acc_q;
    // clear wins so a frame swap starts the new pattern from phase zero
    if (clear_i)       acc_d = '0;
    else if (enable_i) acc_d = sum;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q   <= '0;
      spike_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      spike_q <= enable_i && carry;
    end
  end
`endif

  assign spike_o = spike_q;

endmodule

`default_nettype wire

// File: rtl/spike_encoder.sv
//------------------------------------------------------------------------------
// spike_encoder : double-buffered rate-coded spike frame generator
// Rev 1.0 : initial release (build option SPIKE_ENCODER_LFSR_EN)
//------------------------------------------------------------------------------
`default_nettype none

module spike_encoder #(
  parameter int          CHANNELS  = snn_pkg::CHANNELS,
  parameter int          INT_W     = snn_pkg::INT_W,
  parameter int          FRAME_LEN = 16,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_0001
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_channel,
  input  logic [INT_W-1:0]    in_intensity,
  input  logic                in_last,
  input  logic                in_learn,
  output logic [CHANNELS-1:0] spikes_out,
  output logic                learn_out,
  output logic                frame_start,
  output logic                busy
);

  import snn_pkg::*;

  localparam int             CNT_W    = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  state_e                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           pending_q, pending_d;
  logic [CHANNELS-1:0][INT_W-1:0] shadow_q, shadow_d, active_q;
  logic                           shadow_learn_q, shadow_learn_d, active_learn_q;
  logic                           frame_start_q, learn_q;
  logic                           accept, commit, swap, run, term;
  logic [CHANNELS-1:0]            spikes;

  assign in_ready = !pending_q;
  assign accept   = in_valid && in_ready;
  assign commit   = accept && in_last;
  assign run      = (state_q == ST_RUN);
  assign term     = (cnt_q == CNT_LAST);

  always_comb begin
    shadow_d       = shadow_q;
    shadow_learn_d = shadow_learn_q;
    if (accept) shadow_d[in_channel] = in_intensity;
    if (commit) shadow_learn_d = in_learn;
  end

  // A commit beat on the swap edge is folded straight into the active bank
  always_comb begin
    state_d = state_q;
    swap    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pending_q || commit) begin
          state_d = ST_RUN;
          swap    = 1'b1;
        end
      end
      ST_RUN: begin
        if (term) begin
          if (pending_q || commit) swap    = 1'b1;
          else                     state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    pending_d = swap ? 1'b0 : (pending_q || commit);

    if (swap)            cnt_d = '0;
    else if (run && !term) cnt_d = cnt_q + 1'b1;
    else                 cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      pending_q      <= 1'b0;
      shadow_q       <= '0;
      shadow_learn_q <= 1'b0;
      active_q       <= '0;
      active_learn_q <= 1'b0;
      frame_start_q  <= 1'b0;
      learn_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pending_q      <= pending_d;
      shadow_q       <= shadow_d;
      shadow_learn_q <= shadow_learn_d;
      if (swap) begin
        active_q       <= shadow_d;
        active_learn_q <= shadow_learn_d;
      end
      frame_start_q  <= run && (cnt_q == '0);
      learn_q        <= run && active_learn_q;
    end
  end

`ifdef SPIKE_ENCODER_LFSR_EN
  logic [31:0] lfsr_q, lfsr_d;
  logic [63:0] lfsr_dbl;

  assign lfsr_d   = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
  assign lfsr_dbl = {lfsr_q, lfsr_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    logic [INT_W-1:0] slice;
`ifdef SPIKE_ENCODER_LFSR_EN
    // doubled word lets a slice run past bit 31 and wrap
    assign slice = lfsr_dbl[((4 * i) % 32) +: INT_W];
`else
    assign slice = '0;
`endif
    spike_gen_lane #(
      .INT_W (INT_W)
    ) u_lane (
      .clk          (clk),
      .reset        (reset),
      .intensity_i  (active_q[i]),
      .clear_i      (swap),
      .enable_i     (run),
      .lfsr_slice_i (slice),
      .spike_o      (spikes[i])
    );
  end

  assign spikes_out  = spikes;
  assign learn_out   = learn_q;
  assign frame_start = frame_start_q;
  assign busy        = run;

endmodule

`default_nettype wire

// File: tb/tb_spike_encoder.sv
//------------------------------------------------------------------------------
// tb_spike_encoder : randomized self-checking bench for spike_encoder
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_spike_encoder;

  localparam int FL = 16;
  localparam int IW = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_learn = 1'b0;
  logic [2:0] in_channel = 3'd0;
  logic [3:0] in_intensity = 4'd0;
  logic       in_ready, learn_out, frame_start, busy;
  logic [7:0] spikes_out;

  always #5 clk = ~clk;

  spike_encoder #(
    .CHANNELS  (8),
    .INT_W     (IW),
    .FRAME_LEN (FL),
    .LFSR_SEED (32'hACE1_0001)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_channel   (in_channel),
    .in_intensity (in_intensity),
    .in_last      (in_last),
    .in_learn     (in_learn),
    .spikes_out   (spikes_out),
    .learn_out    (learn_out),
    .frame_start  (frame_start),
    .busy         (busy)
  );

  typedef struct packed {
    logic            learn;
    logic [7:0][3:0] iv;
  } pat_t;

  pat_t            exp_q[$];
  logic [7:0][3:0] shadow_m = '0;
  int              n_tests = 0;
  int              n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A line fires on frame cycle k when floor(k*I/2^W) steps up at k+1
  function automatic logic spike_at(input int k, input int lvl);
    return (((k + 1) * lvl) >> IW) != ((k * lvl) >> IW);
  endfunction

  task automatic send_beat(input logic [2:0] ch, input logic [3:0] v, input logic last,
                           input logic learn);
    int g = 0;
    in_valid = 1'b1; in_channel = ch; in_intensity = v; in_last = last; in_learn = learn;
    while (!in_ready && g < 100) begin
      tick();
      g++;
    end
    if (g >= 100) check_eq("ready_wait", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; in_last = 1'b0; in_learn = 1'b0;
    shadow_m[ch] = v;
    if (last) exp_q.push_back(pat_t'({learn, shadow_m}));
  endtask

  task automatic check_idle(input int n);
    for (int c = 0; c < n; c++) begin
      tick();
      check_eq("idle", 32'({frame_start, learn_out, busy, in_ready, spikes_out}),
               32'({3'b000, 1'b1, 8'h00}));
    end
  endtask

  task automatic expect_frame(input bit immediate);
    pat_t       p;
    int         cnt[8];
    logic [7:0] ev, nz;
    int         g;
    p = (exp_q.size() != 0) ? exp_q.pop_front() : pat_t'('0);
    for (int i = 0; i < 8; i++) begin
      cnt[i] = 0;
      nz[i]  = (p.iv[i] != 4'd0);
    end
    if (immediate) tick();
    else begin
      g = 0;
      do begin tick(); g++; end while (!frame_start && g < 40);
    end
    for (int k = 0; k < FL; k++) begin
      if (k > 0) tick();
      for (int i = 0; i < 8; i++) begin
        ev[i]   = spike_at(k, int'(p.iv[i]));
        cnt[i] += int'(spikes_out[i]);
      end
`ifdef SPIKE_ENCODER_LFSR_EN
      check_eq("spikes_zero_lines", 32'(spikes_out & ~nz), 32'd0);
`else
      check_eq("spikes", 32'(spikes_out), 32'(ev));
`endif
      check_eq("frame_start", 32'(frame_start), 32'(k == 0));
      check_eq("learn_out", 32'(learn_out), 32'(p.learn));
    end
    for (int i = 0; i < 8; i++) begin
`ifdef SPIKE_ENCODER_LFSR_EN
      if (p.iv[i] == 4'd15) check_eq("rate_full", 32'(cnt[i] >= FL - 2), 32'd1);
      else if (p.iv[i] == 4'd0) check_eq("rate_zero", 32'(cnt[i]), 32'd0);
`else
      check_eq("rate", 32'(cnt[i]), 32'((FL * int'(p.iv[i])) >> IW));
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nb;
    repeat (3) tick();
    check_eq("reset_out", 32'({spikes_out, learn_out, frame_start, busy, in_ready}),
             32'({8'h00, 3'b000, 1'b1}));
    reset = 1'b1;
    check_idle(20);

    // rate check: channel i at intensity i, learn set
    for (int ch = 0; ch < 8; ch++) send_beat(3'(ch), 4'(ch), ch == 7, 1'b1);
    check_eq("commit_edge", 32'({busy, frame_start}), 32'(2'b10));
    expect_frame(1);
    check_idle(3);

    // half-rate line 0; other channels keep their shadow values
    send_beat(3'd0, 4'd8, 1'b1, 1'b0);
    expect_frame(1);
    check_idle(2);

    // full and zero intensity boundaries
    for (int ch = 0; ch < 8; ch++) send_beat(3'(ch), (ch == 3) ? 4'd0 : 4'd15, ch == 7, 1'b1);
    expect_frame(1);
    check_idle(1);

    repeat (6) begin
      nb = int'($urandom_range(1, 6));
      for (int j = 0; j < nb; j++)
        send_beat(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), j == nb - 1,
                  1'($urandom_range(0, 1)));
      expect_frame(1);
      check_idle(1);
    end

    // back-to-back frames with a commit blocked by backpressure
    for (int ch = 0; ch < 8; ch++) send_beat(3'(ch), 4'($urandom_range(0, 15)), ch == 7, 1'b0);
    fork
      begin
        expect_frame(1);
        check_eq("ready_after_swap", 32'(in_ready), 32'd1);
        expect_frame(1);
        expect_frame(1);
      end
      begin
        repeat (5) tick();
        send_beat(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'b0, 1'b0);
        send_beat(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'b1, 1'b1);
        check_eq("ready_backpressure", 32'(in_ready), 32'd0);
        send_beat(3'd2, 4'($urandom_range(0, 15)), 1'b1, 1'b0);
      end
    join
    check_idle(2);

    // reset at frame cycle 7
    send_beat(3'd5, 4'd9, 1'b1, 1'b1);
    tick();
    check_eq("mid_frame_start", 32'(frame_start), 32'd1);
    repeat (7) tick();
    reset = 1'b0;
    #1;
    check_eq("reset_mid_frame", 32'({spikes_out, learn_out, frame_start, busy, in_ready}),
             32'({8'h00, 3'b000, 1'b1}));
    exp_q.delete();
    shadow_m = '0;
    repeat (3) tick();
    reset = 1'b1;
    check_idle(20);

    // banks were cleared: only the freshly written channel may spike
    send_beat(3'd4, 4'd11, 1'b1, 1'b1);
    expect_frame(1);
    check_idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
